// File: rtl/uart_tx_scheduler_if.sv
// uart_tx_scheduler_if: source FIFO and UART handshake bundle for the TX scheduler
interface uart_tx_scheduler_if #(parameter int NUM_SRC = 2);
  logic [NUM_SRC-1:0] pkt_req;
  logic [8*NUM_SRC-1:0] fifo_data;
  logic [NUM_SRC-1:0] fifo_valid;
  logic [NUM_SRC-1:0] fifo_pop;
  logic uart_tx_empty;
  logic uart_tx_latch;
  logic [7:0] uart_tx_data;
  logic [NUM_SRC-1:0] grant;
  logic busy;
  logic [NUM_SRC-1:0] pend_ovf;
  modport master (
    input pkt_req, fifo_data, fifo_valid, uart_tx_empty,
    output fifo_pop, uart_tx_latch, uart_tx_data, grant, busy, pend_ovf
  );
  modport slave (
    output pkt_req, fifo_data, fifo_valid, uart_tx_empty,
    input fifo_pop, uart_tx_latch, uart_tx_data, grant, busy, pend_ovf
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin framing of per-source FIFO packets onto one UART transmitter
module uart_tx_scheduler #(
  parameter int NUM_SRC = 2,
  parameter logic [7:0] PREFIX_BASE = 8'h61,
  parameter int MAX_BYTES = 64
) (
  input logic clk,
  input logic resetn,
  uart_tx_scheduler_if.master bus
);
  localparam int IW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
  typedef enum logic [2:0] {IDLE, PREFIX, HI, LO, EOL} state_t;
  state_t state, state_nx;
  logic [IW-1:0] g, rr_last, sel;
  logic [7:0] byte_cnt, head;
  logic [3:0] pend [NUM_SRC];
  logic [NUM_SRC-1:0] pend_nz, dec;
  logic any, valid_g, hi_done, tx_go, eol_go;

  function automatic logic [7:0] hex(input logic [3:0] n);
    return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_nz
    assign pend_nz[i] = |pend[i];
  end

  assign head = 8'(bus.fifo_data >> {g, 3'b000});
  assign valid_g = |(bus.fifo_valid & (NUM_SRC'(1) << g));
  assign hi_done = !valid_g || byte_cnt == 8'(MAX_BYTES);
  assign eol_go = state == EOL && bus.uart_tx_empty;
  assign dec = eol_go ? NUM_SRC'(1) << g : '0;

  // pick the first pending source after rr_last, wrapping; nearest index wins
  always_comb begin
    sel = rr_last;
    any = 1'b0;
    for (int k = NUM_SRC; k >= 1; k--)
      if (pend_nz[(int'(rr_last) + k) % NUM_SRC]) begin
        sel = IW'((int'(rr_last) + k) % NUM_SRC);
        any = 1'b1;
      end
  end

  // state register
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_nx;

  // next-state: every char-emitting state waits for the UART buffer
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = any ? PREFIX : IDLE;
      PREFIX: state_nx = bus.uart_tx_empty ? HI : PREFIX;
      HI: state_nx = hi_done ? EOL : bus.uart_tx_empty ? LO : HI;
      LO: state_nx = bus.uart_tx_empty ? HI : LO;
      EOL: state_nx = bus.uart_tx_empty ? IDLE : EOL;
      default: state_nx = IDLE;
    endcase
  end

  // outputs: latch only into an empty UART, data forced to zero otherwise
  always_comb begin
    tx_go = bus.uart_tx_empty && (state == PREFIX || state == LO || state == EOL || (state == HI && !hi_done));
    bus.uart_tx_latch = tx_go;
    bus.uart_tx_data = !tx_go ? 8'h00 :
                       state == PREFIX ? PREFIX_BASE + 8'({g, 1'b0}) :
                       state == HI ? hex(head[7:4]) :
                       state == LO ? hex(head[3:0]) : 8'h0A;
    bus.fifo_pop = (state == LO && bus.uart_tx_empty) ? NUM_SRC'(1) << g : '0;
    bus.grant = state != IDLE ? NUM_SRC'(1) << g : '0;
    bus.busy = state != IDLE;
  end

  // granted index, payload byte count and round-robin pointer
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      g <= '0;
      byte_cnt <= '0;
      rr_last <= IW'(NUM_SRC - 1);
    end else begin
      if (state == IDLE && any) begin
        g <= sel;
        byte_cnt <= '0;
      end
      if (state == LO && bus.uart_tx_empty) byte_cnt <= byte_cnt + 8'd1;
      if (eol_go) rr_last <= g;
    end

  // per-source pending packet counters; a request coinciding with EOL nets to zero
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      for (int k = 0; k < NUM_SRC; k++) pend[k] <= '0;
      bus.pend_ovf <= '0;
    end else
      for (int k = 0; k < NUM_SRC; k++)
        if (bus.pkt_req[k] && !dec[k]) begin
          if (pend[k] == 4'hF) bus.pend_ovf[k] <= 1'b1;
          else pend[k] <= pend[k] + 4'd1;
        end else if (dec[k] && !bus.pkt_req[k]) pend[k] <= pend[k] - 4'd1;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: table vectors, corner sequences and a random scoreboard for the UART scheduler
module tb_uart_tx_scheduler;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  uart_tx_scheduler_if #(.NUM_SRC(2)) b0 ();
  uart_tx_scheduler_if #(.NUM_SRC(2)) b1 ();
  uart_tx_scheduler #(.NUM_SRC(2), .PREFIX_BASE(8'h61), .MAX_BYTES(64)) d0 (.clk(clk), .resetn(resetn), .bus(b0));
  uart_tx_scheduler #(.NUM_SRC(2), .PREFIX_BASE(8'h61), .MAX_BYTES(2)) d1 (.clk(clk), .resetn(resetn), .bus(b1));

  logic [7:0] mem [2][2][256];
  int wr [2][2], rd [2][2], popc [2][2], hold [2], cnt [2];
  logic [1:0] req [2];
  logic s_lat [2] = '{1'b0, 1'b0};
  logic [7:0] s_dat [2];
  logic [1:0] s_pop [2] = '{2'b00, 2'b00};
  byte unsigned rx0 [$], rx1 [$];
  int viol = 0;
  int n_chk = 0, n_fail = 0;

  logic lat [2], emp [2], bsy [2];
  logic [7:0] dat [2];
  logic [1:0] pop [2], gnt [2], ovf [2];

  assign b0.pkt_req = req[0];
  assign b1.pkt_req = req[1];
  assign b0.fifo_valid = {wr[0][1] != rd[0][1], wr[0][0] != rd[0][0]};
  assign b1.fifo_valid = {wr[1][1] != rd[1][1], wr[1][0] != rd[1][0]};
  assign b0.fifo_data = {mem[0][1][8'(rd[0][1])], mem[0][0][8'(rd[0][0])]};
  assign b1.fifo_data = {mem[1][1][8'(rd[1][1])], mem[1][0][8'(rd[1][0])]};
  assign b0.uart_tx_empty = cnt[0] == 0;
  assign b1.uart_tx_empty = cnt[1] == 0;
  assign lat = '{b0.uart_tx_latch, b1.uart_tx_latch};
  assign emp = '{b0.uart_tx_empty, b1.uart_tx_empty};
  assign bsy = '{b0.busy, b1.busy};
  assign dat = '{b0.uart_tx_data, b1.uart_tx_data};
  assign pop = '{b0.fifo_pop, b1.fifo_pop};
  assign gnt = '{b0.grant, b1.grant};
  assign ovf = '{b0.pend_ovf, b1.pend_ovf};

  function automatic int bad(int k);
    return int'((lat[k] && !emp[k]) || (!lat[k] && dat[k] != 8'h00) || pop[k] == 2'b11 ||
                (pop[k] != 2'b00 && !lat[k]) || (!bsy[k] && gnt[k] != 2'b00) ||
                (bsy[k] && gnt[k] != 2'b01 && gnt[k] != 2'b10));
  endfunction

  // mid-cycle sampling of the DUT handshake plus protocol-rule watch
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      s_lat[k] <= lat[k];
      s_dat[k] <= dat[k];
      s_pop[k] <= pop[k];
    end
    viol <= viol + bad(0) + bad(1);
  end

  // UART buffer and FIFO models commit on the clock edge
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      cnt[k] <= (s_lat[k] && resetn) ? hold[k] : (cnt[k] > 0 ? cnt[k] - 1 : 0);
      for (int s = 0; s < 2; s++)
        if (s_pop[k][s] && resetn) begin
          rd[k][s] <= rd[k][s] + 1;
          popc[k][s] <= popc[k][s] + 1;
        end
    end
    if (s_lat[0] && resetn) rx0.push_back(s_dat[0]);
    if (s_lat[1] && resetn) rx1.push_back(s_dat[1]);
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_str(string name, string act, string exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  task automatic push(int k, int s, logic [7:0] v);
    mem[k][s][8'(wr[k][s])] = v;
    wr[k][s]++;
  endtask

  task automatic wait_idle(int k, int budget, string name);
    int q = 0;
    int n = 0;
    while (q < 4 && n < budget) begin
      @(negedge clk);
      n++;
      q = bsy[k] ? 0 : q + 1;
    end
    chk({name, "_idle"}, 32'(q >= 4), 32'd1);
  endtask

  function automatic string rx_str(int k, int from);
    string s = "";
    byte unsigned c;
    int n = k == 1 ? rx1.size() : rx0.size();
    for (int i = from; i < n; i++) begin
      c = k == 1 ? rx1[i] : rx0[i];
      s = $sformatf("%s%c", s, c == 8'h0A ? 8'h7C : c);
    end
    return s;
  endfunction

  function automatic string hx(logic [7:0] v);
    string dig = "0123456789ABCDEF";
    return $sformatf("%c%c", dig.getc(int'(v[7:4])), dig.getc(int'(v[3:0])));
  endfunction

  function automatic int hexval(byte unsigned c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
    return -1;
  endfunction

  typedef struct {
    logic [1:0] req;
    int hold;
    logic [7:0] b0 [4];
    int n0;
    logic [7:0] b1 [4];
    int n1;
    string exp;
  } vec_t;
  vec_t tbl [6];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int m, p0, p1, n, perr, cur, half, nib, v;
    int nreq [2], en [2], pk [2], gb [2], bmis [2], pb [2];
    logic [7:0] eb [2][512];
    logic [1:0] r;
    string s;
    bit seen;
    tbl[0] = '{2'b11, 0, '{8'h11, 0, 0, 0}, 1, '{8'h22, 0, 0, 0}, 1, "a11|c22|"};
    tbl[1] = '{2'b11, 5, '{8'h7F, 0, 0, 0}, 1, '{8'hE0, 0, 0, 0}, 1, "a7F|cE0|"};
    tbl[2] = '{2'b01, 0, '{8'h3C, 8'hA5, 0, 0}, 2, '{0, 0, 0, 0}, 0, "a3CA5|"};
    tbl[3] = '{2'b10, 0, '{0, 0, 0, 0}, 0, '{0, 0, 0, 0}, 0, "c|"};
    tbl[4] = '{2'b01, 2, '{0, 0, 0, 0}, 0, '{0, 0, 0, 0}, 0, "a|"};
    tbl[5] = '{2'b11, 1, '{8'h00, 8'hFF, 8'h9A, 0}, 3, '{8'h5B, 0, 0, 0}, 1, "c5B|a00FF9A|"};
    req[0] = 2'b00;
    req[1] = 2'b00;
    hold[0] = 0;
    hold[1] = 0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_latch%0d", k), 32'(lat[k]), 32'd0);
      chk($sformatf("rst_data%0d", k), 32'(dat[k]), 32'd0);
      chk($sformatf("rst_busy%0d", k), 32'(bsy[k]), 32'd0);
      chk($sformatf("rst_grant%0d", k), 32'(gnt[k]), 32'd0);
      chk($sformatf("rst_pop%0d", k), 32'(pop[k]), 32'd0);
      chk($sformatf("rst_ovf%0d", k), 32'(ovf[k]), 32'd0);
    end
    resetn = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 6; t++) begin
      m = rx0.size();
      p0 = popc[0][0];
      p1 = popc[0][1];
      hold[0] = tbl[t].hold;
      for (int i = 0; i < tbl[t].n0; i++) push(0, 0, tbl[t].b0[i]);
      for (int i = 0; i < tbl[t].n1; i++) push(0, 1, tbl[t].b1[i]);
      req[0] = tbl[t].req;
      @(negedge clk);
      req[0] = 2'b00;
      wait_idle(0, 2000, $sformatf("vec%0d", t));
      chk_str($sformatf("vec%0d_chars", t), rx_str(0, m), tbl[t].exp);
      chk($sformatf("vec%0d_pops0", t), popc[0][0] - p0, tbl[t].n0);
      chk($sformatf("vec%0d_pops1", t), popc[0][1] - p1, tbl[t].n1);
    end

    m = rx1.size();
    push(1, 0, 8'h12);
    push(1, 0, 8'h34);
    push(1, 0, 8'h56);
    req[1] = 2'b01;
    @(negedge clk);
    req[1] = 2'b00;
    wait_idle(1, 1000, "split1");
    chk_str("split1_chars", rx_str(1, m), "a1234|");
    chk("split1_pops", popc[1][0], 2);
    m = rx1.size();
    req[1] = 2'b01;
    @(negedge clk);
    req[1] = 2'b00;
    wait_idle(1, 1000, "split2");
    chk_str("split2_chars", rx_str(1, m), "a56|");
    chk("split2_pops", popc[1][0], 3);

    m = rx0.size();
    hold[0] = 3;
    s = "a";
    for (int i = 0; i < 20; i++) begin
      push(0, 0, 8'(i * 13 + 7));
      s = {s, hx(8'(i * 13 + 7))};
    end
    s = {s, "|"};
    for (int i = 0; i < 15; i++) s = {s, "c|"};
    req[0] = 2'b01;
    @(negedge clk);
    req[0] = 2'b00;
    n = 0;
    while (!bsy[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 16; i++) begin
      req[0] = 2'b10;
      @(negedge clk);
      req[0] = 2'b00;
      @(negedge clk);
    end
    chk("ovf_grant_src0", 32'(gnt[0]), 32'd1);
    chk("ovf_flags", 32'(ovf[0]), 32'd2);
    wait_idle(0, 4000, "ovf_drain");
    chk_str("ovf_chars", rx_str(0, m), s);
    chk("ovf_sticky", 32'(ovf[0]), 32'd2);

    hold[0] = 0;
    push(0, 0, 8'hAB);
    push(0, 0, 8'hCD);
    req[0] = 2'b01;
    @(negedge clk);
    req[0] = 2'b00;
    n = 0;
    while (!pop[0][0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("lo_pop_seen", 32'(pop[0][0]), 32'd1);
    chk("lo_latch_seen", 32'(lat[0]), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("arst_latch", 32'(lat[0]), 32'd0);
    chk("arst_pop", 32'(pop[0]), 32'd0);
    chk("arst_busy", 32'(bsy[0]), 32'd0);
    chk("arst_grant", 32'(gnt[0]), 32'd0);
    chk("arst_ovf", 32'(ovf[0]), 32'd0);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 2; j++) wr[k][j] = rd[k][j];
    resetn = 1'b1;
    m = rx0.size();
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen |= bsy[0];
    end
    chk("post_rst_idle", 32'(seen), 32'd0);
    chk("post_rst_chars", rx0.size() - m, 0);
    push(0, 0, 8'hC3);
    req[0] = 2'b01;
    @(negedge clk);
    req[0] = 2'b00;
    wait_idle(0, 1000, "post_rst_pkt");
    chk_str("post_rst_pkt_chars", rx_str(0, m), "aC3|");

    m = rx0.size();
    pb[0] = popc[0][0];
    pb[1] = popc[0][1];
    for (int s2 = 0; s2 < 2; s2++) begin
      nreq[s2] = 0;
      en[s2] = 0;
      pk[s2] = 0;
      gb[s2] = 0;
      bmis[s2] = 0;
    end
    for (int it = 0; it < 40; it++) begin
      r = 2'($urandom_range(1, 3));
      hold[0] = $urandom_range(0, 3);
      for (int s2 = 0; s2 < 2; s2++)
        if (r[s2]) begin
          n = $urandom_range(0, 5);
          for (int i = 0; i < n; i++) begin
            v = $urandom_range(0, 255);
            push(0, s2, 8'(v));
            eb[s2][en[s2]] = 8'(v);
            en[s2]++;
          end
          nreq[s2]++;
        end
      req[0] = r;
      @(negedge clk);
      req[0] = 2'b00;
      repeat ($urandom_range(0, 40)) @(negedge clk);
      if (it % 4 == 3) wait_idle(0, 3000, "rnd_group");
    end
    wait_idle(0, 5000, "rnd_final");
    perr = 0;
    cur = -1;
    half = 0;
    nib = 0;
    for (int i = m; i < rx0.size(); i++) begin
      if (cur < 0) begin
        if (rx0[i] == 8'h61) cur = 0;
        else if (rx0[i] == 8'h63) cur = 1;
        else perr++;
      end else if (rx0[i] == 8'h0A) begin
        if (half != 0) perr++;
        pk[cur]++;
        cur = -1;
        half = 0;
      end else if (hexval(rx0[i]) < 0) perr++;
      else if (half == 0) begin
        nib = hexval(rx0[i]);
        half = 1;
      end else begin
        v = nib * 16 + hexval(rx0[i]);
        if (gb[cur] >= en[cur] || 8'(v) != eb[cur][gb[cur]]) bmis[cur]++;
        gb[cur]++;
        half = 0;
      end
    end
    if (cur >= 0) perr++;
    chk("rnd_parse_errors", perr, 0);
    for (int s2 = 0; s2 < 2; s2++) begin
      chk($sformatf("rnd_packets%0d", s2), pk[s2], nreq[s2]);
      chk($sformatf("rnd_bytes%0d", s2), gb[s2], en[s2]);
      chk($sformatf("rnd_byte_mismatch%0d", s2), bmis[s2], 0);
      chk($sformatf("rnd_pops%0d", s2), popc[0][s2] - pb[s2], en[s2]);
    end
    chk("rnd_ovf", 32'(ovf[0]), 32'd0);
    chk("protocol_violations", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
